// File: rtl/f1_rt_pkg.sv
// Shared types and constants for the F1 reaction timer.
package f1_rt_pkg;

    typedef enum logic [2:0] {IDLE, HOLD, REACT, DONE, FOUL} rt_state_t;

    localparam logic [7:0] ALL_ON    = 8'hFF;
    localparam logic [7:0] FOUL_PAT  = 8'h81;
    localparam logic [6:0] LFSR_SEED = 7'h01;

endpackage

// File: rtl/f1_reaction_timer_lfsr7.sv
// Free-running 7-bit Fibonacci LFSR (x^7 + x^6 + 1), advances every clock.
module lfsr7
    import f1_rt_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    output logic [6:0] data_out
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) data_out <= LFSR_SEED;
        else      data_out <= {data_out[5:0], data_out[6] ^ data_out[5]};
    end

endmodule

// File: rtl/f1_reaction_timer.sv
// F1 reaction timer: holds the start-light FSM for a random delay, then times the driver's response.
// Optional macro RT_TRIG_SYNC_EN adds a 2-flop synchroniser on the trigger input.
module f1_reaction_timer
    import f1_rt_pkg::*;
#(
    parameter int CNT_W   = 16,
    parameter int LFSR_W  = 7,
    parameter int BASE_MS = 200,
    parameter int MAX_MS  = 9999
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ms_tick,
    input  logic [7:0]       lights,
    input  logic             trigger,
    output logic [7:0]       lights_out,
    output logic             fsm_hold,
    output logic [CNT_W-1:0] time_ms,
    output logic             valid,
    output logic             foul
);

    rt_state_t         state, state_d;
    logic [CNT_W-1:0]  delay_cnt, delay_d, time_d;
    logic              valid_d, foul_d;
    logic [LFSR_W-1:0] lfsr;
    logic              trig_s, trig_q, trig_rise;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (v >= CNT_W'(MAX_MS)) return CNT_W'(MAX_MS);
        return v + 1'b1;
    endfunction

    lfsr7 u_lfsr (
        .clk      (clk),
        .rst      (rst),
        .data_out (lfsr)
    );

`ifdef RT_TRIG_SYNC_EN
    logic [1:0] sync_q;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) sync_q <= '0;
        else      sync_q <= {sync_q[0], trigger};
    end
    assign trig_s = sync_q[1];
`else
    assign trig_s = trigger;
`endif

    assign trig_rise = trig_s & ~trig_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            delay_cnt <= '0;
            time_ms   <= '0;
            valid     <= 1'b0;
            foul      <= 1'b0;
            fsm_hold  <= 1'b0;
            trig_q    <= 1'b0;
        end else begin
            state     <= state_d;
            delay_cnt <= delay_d;
            time_ms   <= time_d;
            valid     <= valid_d;
            foul      <= foul_d;
            fsm_hold  <= (state_d != IDLE);
            trig_q    <= trig_s;
        end
    end

    always_comb begin
        state_d = state;
        delay_d = delay_cnt;
        time_d  = time_ms;
        valid_d = valid;
        foul_d  = foul;
        case (state)
            IDLE: begin
                if (lights == ALL_ON) begin
                    state_d = HOLD;
                    delay_d = CNT_W'(BASE_MS) + CNT_W'(lfsr);
                    time_d  = '0;
                    valid_d = 1'b0;
                    foul_d  = 1'b0;
                end
            end
            HOLD: begin
                // A press while the lights are still lit wins over a tick in the same cycle.
                if (trig_rise) begin
                    state_d = FOUL;
                    foul_d  = 1'b1;
                end else if (ms_tick) begin
                    delay_d = delay_cnt - 1'b1;
                    if (delay_cnt == CNT_W'(1)) state_d = REACT;
                end
            end
            REACT: begin
                if (trig_rise) begin
                    state_d = DONE;
                    valid_d = 1'b1;
                end else if (ms_tick) begin
                    time_d = sat_inc(time_ms);
                end
            end
            DONE: begin
                if (trig_rise) state_d = IDLE;
            end
            FOUL: begin
                time_d = '0;
                if (trig_rise) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        case (state)
            IDLE, HOLD: lights_out = lights;
            FOUL:       lights_out = FOUL_PAT;
            default:    lights_out = 8'h00;
        endcase
    end

endmodule

// File: tb/tb_f1_reaction_timer.sv
// Scoreboard bench for f1_reaction_timer: stimulus queues expected results, a monitor checks them.
`timescale 1ns/1ps
module tb_f1_reaction_timer;

`ifdef RT_TRIG_SYNC_EN
    localparam int SYNC_LAT = 2;
`else
    localparam int SYNC_LAT = 0;
`endif
    localparam int EV_VALID = 0;
    localparam int EV_FOUL  = 1;

    typedef struct {
        int kind;
        int t;
    } exp_t;
    exp_t expq[$];

    logic        clk = 1'b0;
    logic        rst, ms_tick, trigger;
    logic [7:0]  lights, lights_out;
    logic        fsm_hold, valid, foul;
    logic [15:0] time_ms;
    logic [6:0]  m_lfsr, edge_lfsr;
    int          nchecks, nerr;
    int          d;

    always #5 clk = ~clk;

    f1_reaction_timer #(
        .CNT_W(16), .LFSR_W(7), .BASE_MS(200), .MAX_MS(9999)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .ms_tick    (ms_tick),
        .lights     (lights),
        .trigger    (trigger),
        .lights_out (lights_out),
        .fsm_hold   (fsm_hold),
        .time_ms    (time_ms),
        .valid      (valid),
        .foul       (foul)
    );

    task automatic chk(input string name, input int act, input int exp);
        nchecks++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // One clock edge; tracks the LFSR value the DUT uses at that edge.
    task automatic step();
        @(posedge clk);
        edge_lfsr = m_lfsr;
        m_lfsr = rst ? {m_lfsr[5:0], m_lfsr[6] ^ m_lfsr[5]} : 7'h01;
        #1;
    endtask

    task automatic ticks(input int n);
        ms_tick = 1'b1;
        repeat (n) step();
        ms_tick = 1'b0;
    endtask

    task automatic press();
        trigger = 1'b1;
        repeat (1 + SYNC_LAT) step();
    endtask

    task automatic unpress();
        trigger = 1'b0;
        repeat (1 + SYNC_LAT) step();
    endtask

    task automatic expect_ev(input int kind, input int t);
        exp_t e;
        e.kind = kind;
        e.t    = t;
        expq.push_back(e);
    endtask

    task automatic got(input int kind);
        exp_t e;
        if (expq.size() == 0) begin
            chk("unexpected_event", kind, -1);
        end else begin
            e = expq.pop_front();
            chk("event_kind", kind, e.kind);
            chk("event_time", int'(time_ms), e.t);
        end
    endtask

    task automatic enter_hold(output int dly);
        logic [7:0] pat;
        pat = 8'h00;
        for (int i = 0; i < 8; i++) begin
            pat = {pat[6:0], 1'b1};
            lights = pat;
            step();
            if (i == 6) chk("hold_low_before_ff", fsm_hold, 0);
        end
        dly = 200 + int'(edge_lfsr);
        chk("hold_on_entry", fsm_hold, 1);
        chk("lights_pass_hold", lights_out, 8'hFF);
    endtask

    task automatic back_to_idle();
        unpress();
        lights = 8'h00;
        press();
        chk("idle_hold_released", fsm_hold, 0);
        unpress();
    endtask

    initial begin
        nchecks = 0;
        nerr    = 0;
        rst     = 1'b0;
        ms_tick = 1'b0;
        trigger = 1'b0;
        lights  = 8'h3C;
        m_lfsr  = 7'h01;
        edge_lfsr = 7'h01;

        fork
            begin
                logic pv, pf;
                pv = 1'b0;
                pf = 1'b0;
                forever begin
                    @(negedge clk);
                    if (valid && !pv) got(EV_VALID);
                    if (foul && !pf)  got(EV_FOUL);
                    pv = valid;
                    pf = foul;
                end
            end
        join_none

        #12;
        chk("rst_lights_out", lights_out, 8'h3C);
        chk("rst_fsm_hold", fsm_hold, 0);
        chk("rst_time_ms", time_ms, 0);
        chk("rst_valid", valid, 0);
        chk("rst_foul", foul, 0);
        lights = 8'h00;
        step();
        rst = 1'b1;

        // Trigger in IDLE does nothing.
        press();
        chk("idle_trig_ignored", fsm_hold, 0);
        chk("idle_trig_no_valid", valid, 0);
        unpress();

        // Normal run: 250 ms reaction.
        enter_hold(d);
        ticks(d - 1);
        chk("still_hold_lit", lights_out, 8'hFF);
        ticks(1);
        chk("react_dark", lights_out, 8'h00);
        chk("react_hold", fsm_hold, 1);
        ticks(250);
        chk("react_time_250", time_ms, 250);
        expect_ev(EV_VALID, 250);
        press();
        chk("done_dark", lights_out, 8'h00);
        back_to_idle();
        chk("valid_kept_idle", valid, 1);

        // Jump start 50 ms into HOLD.
        enter_hold(d);
        chk("valid_clear_on_hold", valid, 0);
        ticks(50);
        expect_ev(EV_FOUL, 0);
        press();
        chk("foul_pattern", lights_out, 8'h81);
        chk("foul_hold", fsm_hold, 1);
        chk("foul_time", time_ms, 0);
        back_to_idle();
        chk("foul_lights_pass", lights_out, 8'h00);
        chk("foul_kept_idle", foul, 1);

        // Saturation at 9999.
        enter_hold(d);
        chk("foul_clear_on_hold", foul, 0);
        ticks(d + 12000);
        chk("sat_time", time_ms, 9999);
        expect_ev(EV_VALID, 9999);
        press();
        back_to_idle();

        // Trigger edge and tick together at 100: no increment.
        enter_hold(d);
        ticks(d + 100);
        expect_ev(EV_VALID, 100);
        trigger = 1'b1;
        repeat (SYNC_LAT) step();
        ms_tick = 1'b1;
        step();
        ms_tick = 1'b0;
        chk("coincide_time", time_ms, 100);
        back_to_idle();

        // Trigger already high entering REACT: needs release and re-press.
        trigger = 1'b1;
        repeat (2 + SYNC_LAT) step();
        enter_hold(d);
        ticks(d + 20);
        chk("held_no_capture", valid, 0);
        chk("held_still_react", lights_out, 8'h00);
        trigger = 1'b0;
        ticks(10);
        expect_ev(EV_VALID, 30);
        press();
        back_to_idle();

        // Reset in the middle of REACT.
        enter_hold(d);
        ticks(d + 40);
        chk("pre_rst_time", time_ms, 40);
        #2;
        rst = 1'b0;
        #1;
        chk("midrst_lights_pass", lights_out, 8'hFF);
        chk("midrst_fsm_hold", fsm_hold, 0);
        chk("midrst_time_ms", time_ms, 0);
        chk("midrst_valid", valid, 0);
        lights = 8'h00;
        step();
        rst = 1'b1;

        // After reset the LFSR restarts from its seed.
        enter_hold(d);
        ticks(d - 1);
        chk("post_rst_still_lit", lights_out, 8'hFF);
        ticks(1);
        chk("post_rst_react_dark", lights_out, 8'h00);
        expect_ev(EV_VALID, 0);
        press();
        back_to_idle();

        repeat (3) step();
        chk("queue_drained", expq.size(), 0);
        $display("Result: errors=%0d of %0d checks", nerr, nchecks);
        $finish;
    end

endmodule

// File: doc/f1_reaction_timer.md
Name: f1_reaction_timer

Overview:
- Sits directly downstream of the F1 start-light FSM. It consumes the FSM's 8-bit light pattern plus the 1 kHz tick from clktick.
- Once all eight lights are lit, it holds the FSM and waits a pseudo-random delay. It then blanks the lights and measures, in milliseconds, the time until the driver presses the trigger.
- Reports a jump start (foul) if the trigger is pressed before the lights go out.
- The top level gates the FSM enable with fsm_hold and drives the LED bank from lights_out.

Parameters:
- CNT_W, 16, width of the reaction-time counter and the delay counter.
- LFSR_W, 7, width of the random-delay LFSR; fixed taps for 7.
- BASE_MS, 200, minimum hold delay in ms.
- MAX_MS, 9999, saturation value of time_ms.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- ms_tick  in  1  one-cycle pulse every 1 ms, from clktick.
- lights  in  8  light pattern from the F1 FSM.
- trigger  in  1  driver button, level, active-high.
- lights_out  out  8  gated light pattern to the LEDs.
- fsm_hold  out  1  high means the top must suppress the FSM enable.
- time_ms  out  CNT_W  measured reaction time in ms.
- valid  out  1  time_ms holds a valid result.
- foul  out  1  jump start detected.

Behaviour:
- Reset (rst=0, asynchronous) values:
  - state=IDLE, lfsr=7'h01, delay_cnt=0, time_ms=0.
  - valid=0, foul=0, fsm_hold=0, trig_q=0.
  - lights_out follows the IDLE rule below.
- LFSR:
  - 7-bit Fibonacci, x^7+x^6+1; new bit = lfsr[6]^lfsr[5], shifted in at bit 0.
  - Advances every clk in every state. The all-zero state is never reached.
- Trigger edge: trig_rise = trigger & ~trig_q; trig_q is registered every clk.
- IDLE:
  - lights_out=lights, fsm_hold=0.
  - If lights==8'hFF: go to HOLD. Load delay_cnt = BASE_MS + lfsr (zero-extended), giving a delay of 201..327 ms. Clear valid, foul, time_ms.
  - A trigger edge in IDLE is ignored.
- HOLD:
  - lights_out=lights, fsm_hold=1.
  - Each ms_tick decrements delay_cnt.
  - ms_tick with delay_cnt==1: go to REACT next cycle.
  - trig_rise: go to FOUL and set foul=1. A trigger edge takes priority over a ms_tick in the same cycle.
- REACT:
  - lights_out=8'h00, fsm_hold=1.
  - Each ms_tick increments time_ms, saturating at MAX_MS.
  - trig_rise: go to DONE and set valid=1. If trig_rise and ms_tick coincide, no increment is applied.
  - If trigger is already high on REACT entry, there is no edge, so the block waits for release and re-press.
- DONE:
  - lights_out=8'h00, fsm_hold=1. time_ms and valid are held.
  - trig_rise: go to IDLE; valid stays 1 until the next HOLD entry.
- FOUL:
  - lights_out=8'h81, fsm_hold=1, foul=1, time_ms=0.
  - trig_rise: go to IDLE; foul stays 1 until the next HOLD entry.
- Latency and output timing:
  - All state and outputs are registered except lights_out, which is combinational from state and lights.
  - lights_out drops to 0 in the first cycle of REACT.
- Reset mid-operation: immediate return to IDLE with all reset values; fsm_hold is released.

Optional Feature:
- Macro RT_TRIG_SYNC_EN.
- Defined: trigger passes through a 2-flop synchroniser (reset 0) before edge detection, adding 2 clk of latency to all trigger responses.
- Undefined: trigger is used directly and must be synchronous to clk.

Decomposition:
- Package f1_rt_pkg holds:
  - typedef enum logic [2:0] rt_state_t {IDLE, HOLD, REACT, DONE, FOUL};
  - constants ALL_ON=8'hFF, FOUL_PAT=8'h81, LFSR_SEED=7'h01.
- Sub-module lfsr7: free-running 7-bit LFSR with clk, rst, and a data_out port.

Test Plan:
- Reset, then drive lights 00->01->...->FF: expect HOLD, fsm_hold=1, and delay_cnt = 200 + lfsr value at entry (e.g. 200 + 7'h01 gives 201 if entry is on cycle 0).
- HOLD: after the loaded number of ms_ticks, lights_out=00 in REACT. Press trigger after 250 ticks: expect DONE, time_ms=250, valid=1.
- Press trigger 50 ticks into HOLD: expect FOUL, foul=1, lights_out=81, time_ms=0. Press again: expect IDLE, fsm_hold=0.
- REACT with no trigger for 12000 ticks: expect time_ms saturates at 9999. Then trigger: expect valid=1, time_ms=9999.
- Edge cases in REACT:
  - Trigger edge and ms_tick in the same cycle at time_ms=100: expect final 100.
  - Trigger held high entering REACT: no capture until release and re-press.
- Assert rst low in REACT: expect IDLE immediately, lights_out=lights, time_ms=0, valid=0. With RT_TRIG_SYNC_EN defined, DONE entry is 2 clk later than without.
